nios2_oci_dct_packer: RTL and testbench
=======================================

Name: nios2_oci_dct_packer

Overview:
Packs the 2-bit data-trace atoms from the Nios II OCI into 30-bit frames of up to 15 atoms, with a 4-bit atom count per frame. Frames go to the trace buffer over a valid/ready handshake. The block also drives the live dct_buffer/dct_count and end-of-test signals that the OCI simulation test bench consumes. It is the producer end of that dct_buffer/dct_count interface.

Parameters:
ATOM_W, 2, width of one trace atom
DEPTH, 15, atoms per full frame; buffer width = ATOM_W*DEPTH = 30
CNT_W, 4, width of atom count fields
DROP_W, 8, width of saturating dropped-atom counter

Ports:
clk  in  1  single clock, all logic rising-edge
reset_n  in  1  synchronous active-low reset
atom_valid  in  1  atom present this cycle (source cannot stall)
atom_data  in  2  trace atom; all 4 codes legal
atom_ready  out  1  atom will be accepted this cycle
flush  in  1  request to emit partial frame
frame_valid  out  1  output frame held
frame_data  out  30  packed frame
frame_count  out  4  atoms in frame, 1..15
frame_ready  in  1  sink accepts frame
dct_buffer  out  30  live accumulator contents
dct_count  out  4  live accumulator atom count, 0..15
drop_count  out  8  atoms lost while atom_ready=0, saturating
test_ending  in  1  begin end-of-test drain
test_has_ended  out  1  drain complete, sticky

Behaviour:
- Reset (reset_n=0 at clk edge):
  - acc=0, cnt=0, frame_valid=0, frame_data=0, frame_count=0.
  - drop_count=0, flush_pend=0, state=RUN, test_has_ended=0.
- dct_buffer=acc and dct_count=cnt, driven directly from registers.
- accept = atom_valid & atom_ready.
- Packing on accept:
  - acc <= {acc[27:0], atom_data}; cnt <= cnt+1.
  - The newest atom is always in bits [1:0].
  - In a frame of n atoms, the oldest atom sits at [2n-1:2n-2] and bits above 2n-1 are zero.
- Ready rules:
  - atom_ready = (state==RUN) & (cnt<15).
  - An atom with atom_valid=1 and atom_ready=0 in RUN is dropped and increments drop_count, saturating at 255.
  - Atoms in DRAIN/ENDED are ignored and not counted.
- out_free = ~frame_valid | frame_ready.
- launch = out_free & ((cnt==15) | ((flush_pend | flush) & cnt!=0)).
- On launch:
  - frame_data <= acc; frame_count <= cnt; frame_valid <= 1; flush_pend <= 0.
  - acc/cnt clear, except an atom accepted in the same cycle becomes acc={28'b0,atom}, cnt=1. It is not part of the launched frame.
- If frame_valid & frame_ready and no launch, frame_valid <= 0 next cycle.
- Back-to-back frames: a launch in the same cycle as a frame handshake replaces the frame with no bubble.
- Flush:
  - flush with cnt!=0 that cannot launch (output occupied) sets flush_pend; it launches when out_free.
  - flush with cnt==0 and no pending data is ignored; no empty frames are ever emitted.
- Full accumulator: cnt==15 with output blocked deasserts atom_ready. Launch is 0-cycle once frame_ready rises.
- State machine:
  - RUN -> DRAIN when test_ending=1. Entering DRAIN sets flush_pend.
  - DRAIN -> ENDED when cnt==0 & ~frame_valid & ~flush_pend. Evaluated every cycle, so test_ending with everything empty reaches ENDED in 2 cycles.
  - ENDED holds until reset. test_has_ended=1 only in ENDED.
  - test_ending deassertion has no effect after RUN.
- Reset mid-frame discards acc and the held frame with no handshake. frame_valid drops the cycle after the reset edge.
- Latency: the 15th atom accepted at edge N gives frame_valid=1 after edge N+1, provided the output is free.

Test Plan:
- 15 atoms 0,1,2,3,0,… with frame_ready=1 -> one frame, frame_count=15, frame_data=30'h06C6C6C6 (first atom 0 at [29:28]), then dct_count=0; this value is the repeating pattern 0,1,2,3 per byte from the oldest end; the bench recomputes it from the packing rule.
- 3 atoms 3,2,1 then flush pulse -> frame_count=3, frame_data=30'h39; no frame on a second flush with cnt=0.
- frame_ready=0, 40 atoms -> frame 1 held, acc fills to 15, atom_ready=0, drop_count=10; raise frame_ready -> frame 2 launches the same cycle frame 1 is taken.
- flush in the same cycle as an atom, cnt=5 -> frame_count=5 emitted, new acc holds that atom, dct_count=1.
- 7 atoms then test_ending with frame_ready=1 -> 7-atom frame emitted, then test_has_ended=1 sticky; later atoms are ignored and drop_count is unchanged.
- reset_n low for 1 cycle with frame_valid=1, cnt=9 -> all outputs zero next cycle, state RUN.

Source files
------------

// File: rtl/nios2_oci_dct_packer_if.sv
// Bundle of the atom, frame, live-accumulator and end-of-test signals of the DCT packer.
// master: the packer itself; slave: the trace source / trace buffer / OCI test bench side.
interface nios2_oci_dct_packer_if;
    localparam int unsigned ATOM_W = 2;
    localparam int unsigned DEPTH  = 15;
    localparam int unsigned BUF_W  = ATOM_W * DEPTH;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DROP_W = 8;

    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;
    logic              atom_ready;
    logic              flush;
    logic              frame_valid;
    logic [BUF_W-1:0]  frame_data;
    logic [CNT_W-1:0]  frame_count;
    logic              frame_ready;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic [DROP_W-1:0] drop_count;
    logic              test_ending;
    logic              test_has_ended;

    modport master (
        input  atom_valid, atom_data, flush, frame_ready, test_ending,
        output atom_ready, frame_valid, frame_data, frame_count,
               dct_buffer, dct_count, drop_count, test_has_ended
    );

    modport slave (
        output atom_valid, atom_data, flush, frame_ready, test_ending,
        input  atom_ready, frame_valid, frame_data, frame_count,
               dct_buffer, dct_count, drop_count, test_has_ended
    );
endinterface

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit OCI data-trace atoms into 30-bit frames of up to 15 atoms and
// hands them to the trace buffer; also sequences the end-of-test drain.
module nios2_oci_dct_packer (
    input  logic                          clk,
    input  logic                          reset_n,
    nios2_oci_dct_packer_if.master        bus
);
    localparam int unsigned ATOM_W = 2;
    localparam int unsigned DEPTH  = 15;
    localparam int unsigned BUF_W  = ATOM_W * DEPTH;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DROP_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BUF_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                frame_valid_q, frame_valid_d;
    logic [BUF_W-1:0]    frame_data_q, frame_data_d;
    logic [CNT_W-1:0]    frame_count_q, frame_count_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                flush_pend_q, flush_pend_d;
    logic                ready_q, ready_d;
    logic                ended_q, ended_d;

    logic                accept;
    logic                out_free;
    logic                launch;
    logic                enter_drain;
    logic                cnt_full;
    logic                cnt_nz;

    // Next-state: packing, frame hand-off, drop counting and drain sequencing.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        frame_valid_d = frame_valid_q;
        frame_data_d  = frame_data_q;
        frame_count_d = frame_count_q;
        drop_d        = drop_q;
        flush_pend_d  = flush_pend_q;
        ready_d       = ready_q;
        ended_d       = ended_q;

        cnt_full    = (cnt_q == CNT_W'(DEPTH));
        cnt_nz      = (cnt_q != '0);
        accept      = bus.atom_valid & ready_q;
        out_free    = ~frame_valid_q | bus.frame_ready;
        launch      = out_free & (cnt_full | ((flush_pend_q | bus.flush) & cnt_nz));
        enter_drain = (state_q == RUN) & bus.test_ending;

        if (launch) begin
            frame_data_d  = acc_q;
            frame_count_d = cnt_q;
            frame_valid_d = 1'b1;
            acc_d         = '0;
            cnt_d         = '0;
        end else if (frame_valid_q & bus.frame_ready) begin
            frame_valid_d = 1'b0;
        end

        // An atom taken alongside a launch lands in the freshly cleared accumulator.
        if (accept) begin
            acc_d = {acc_d[BUF_W-ATOM_W-1:0], bus.atom_data};
            cnt_d = cnt_d + CNT_W'(1);
        end

        if ((state_q == RUN) & bus.atom_valid & ~ready_q & (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end

        // Pending flush only survives while there is still data left to flush.
        flush_pend_d = ((flush_pend_q | bus.flush) & cnt_nz & ~launch)
                     | (enter_drain & (cnt_d != '0));

        case (state_q)
            RUN:     if (bus.test_ending) state_d = DRAIN;
            DRAIN:   if (~cnt_nz & ~frame_valid_q & ~flush_pend_q) state_d = ENDED;
            ENDED:   state_d = ENDED;
            default: state_d = RUN;
        endcase

        ready_d = (state_d == RUN) & (cnt_d < CNT_W'(DEPTH));
        ended_d = (state_d == ENDED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            acc_q         <= '0;
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_count_q <= '0;
            drop_q        <= '0;
            flush_pend_q  <= 1'b0;
            ready_q       <= 1'b1;
            ended_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            frame_count_q <= frame_count_d;
            drop_q        <= drop_d;
            flush_pend_q  <= flush_pend_d;
            ready_q       <= ready_d;
            ended_q       <= ended_d;
        end
    end

    assign bus.atom_ready     = ready_q;
    assign bus.frame_valid    = frame_valid_q;
    assign bus.frame_data     = frame_data_q;
    assign bus.frame_count    = frame_count_q;
    assign bus.dct_buffer     = acc_q;
    assign bus.dct_count      = cnt_q;
    assign bus.drop_count     = drop_q;
    assign bus.test_has_ended = ended_q;
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Bench for nios2_oci_dct_packer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed frame values.
module tb_nios2_oci_dct_packer;
    logic clk;
    logic reset_n;

    nios2_oci_dct_packer_if bus();

    nios2_oci_dct_packer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accumulator as a queue of atoms, oldest first.
    logic [1:0]  mq[$];
    logic        m_fv;
    logic [29:0] m_fdata;
    int          m_fcnt;
    logic        m_pend;
    int          m_phase;   // 0 running, 1 draining, 2 ended
    int          m_drop;

    int          s_n;
    logic        s_rdy, s_acc, s_free, s_launch, s_enter, s_done, s_pend;

    function automatic logic [29:0] pack_q();
        longint r = 0;
        for (int i = 0; i < mq.size(); i++) r = r * 4 + longint'(mq[i]);
        return 30'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            mq.delete();
            m_fv = 1'b0; m_fdata = '0; m_fcnt = 0;
            m_pend = 1'b0; m_phase = 0; m_drop = 0;
        end else begin
            s_n      = mq.size();
            s_rdy    = (m_phase == 0) && (s_n < 15);
            s_acc    = bus.atom_valid && s_rdy;
            if (m_phase == 0 && bus.atom_valid && !s_rdy && m_drop < 255) m_drop++;
            s_free   = !m_fv || bus.frame_ready;
            s_launch = s_free && (s_n == 15 || ((m_pend || bus.flush) && s_n != 0));
            s_enter  = (m_phase == 0) && bus.test_ending;
            s_done   = (m_phase == 1) && s_n == 0 && !m_fv && !m_pend;
            s_pend   = (m_pend || bus.flush) && s_n != 0 && !s_launch;
            if (s_launch) begin
                m_fdata = pack_q();
                m_fcnt  = s_n;
                m_fv    = 1'b1;
                mq.delete();
            end else if (m_fv && bus.frame_ready) begin
                m_fv = 1'b0;
            end
            if (s_acc) mq.push_back(bus.atom_data);
            m_pend = s_pend || (s_enter && mq.size() != 0);
            if (s_enter) m_phase = 1;
            else if (s_done) m_phase = 2;
        end
    endtask

    initial begin
        mq.delete();
        m_fv = 1'b0; m_fdata = '0; m_fcnt = 0; m_pend = 1'b0; m_phase = 0; m_drop = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("atom_ready",     32'(bus.atom_ready),     32'((m_phase == 0) && (mq.size() < 15)));
            check("frame_valid",    32'(bus.frame_valid),    32'(m_fv));
            check("frame_data",     32'(bus.frame_data),     32'(m_fdata));
            check("frame_count",    32'(bus.frame_count),    32'(m_fcnt));
            check("dct_buffer",     32'(bus.dct_buffer),     32'(pack_q()));
            check("dct_count",      32'(bus.dct_count),      32'(mq.size()));
            check("drop_count",     32'(bus.drop_count),     32'(m_drop));
            check("test_has_ended", 32'(bus.test_has_ended), 32'(m_phase == 2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] a);
        bus.atom_valid = 1'b1;
        bus.atom_data  = a;
        step();
        bus.atom_valid = 1'b0;
    endtask

    logic [1:0] seq4[5];
    logic       seen7;

    initial begin
        reset_n         = 1'b0;
        bus.atom_valid  = 1'b0;
        bus.atom_data   = 2'd0;
        bus.flush       = 1'b0;
        bus.frame_ready = 1'b1;
        bus.test_ending = 1'b0;
        step();
        step();
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_atom_ready",  32'(bus.atom_ready),  32'd1);
        reset_n = 1'b1;
        step();

        // Full 15-atom frame.
        for (int i = 0; i < 15; i++) send(2'(i % 4));
        check("full_dct_count_pre", 32'(bus.dct_count), 32'd15);
        step();
        check("full_frame_valid", 32'(bus.frame_valid), 32'd1);
        check("full_frame_count", 32'(bus.frame_count), 32'd15);
        check("full_frame_data",  32'(bus.frame_data),  32'h06C6C6C6);
        check("full_dct_count",   32'(bus.dct_count),   32'd0);
        step();

        // Partial frame by flush, then an empty flush emits nothing.
        send(2'd3); send(2'd2); send(2'd1);
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        check("flush_frame_count", 32'(bus.frame_count), 32'd3);
        check("flush_frame_data",  32'(bus.frame_data),  32'h39);
        step();
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        step();
        check("empty_flush_valid", 32'(bus.frame_valid), 32'd0);

        // Blocked output: second frame fills, overflow atoms dropped.
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.atom_valid = 1'b1;
            bus.atom_data  = 2'((i * 3) % 4);
            step();
        end
        bus.atom_valid = 1'b0;
        check("blk_drop_count",  32'(bus.drop_count),  32'd10);
        check("blk_atom_ready",  32'(bus.atom_ready),  32'd0);
        check("blk_dct_count",   32'(bus.dct_count),   32'd15);
        check("blk_frame_valid", 32'(bus.frame_valid), 32'd1);
        bus.frame_ready = 1'b1;
        step();
        check("b2b_frame_valid", 32'(bus.frame_valid), 32'd1);
        check("b2b_dct_count",   32'(bus.dct_count),   32'd0);
        step();
        step();

        // Flush coinciding with an accepted atom at cnt=5.
        seq4[0] = 2'd1; seq4[1] = 2'd2; seq4[2] = 2'd3; seq4[3] = 2'd0; seq4[4] = 2'd1;
        for (int i = 0; i < 5; i++) send(seq4[i]);
        bus.flush = 1'b1; bus.atom_valid = 1'b1; bus.atom_data = 2'd3;
        step();
        bus.flush = 1'b0; bus.atom_valid = 1'b0;
        check("fa_frame_count", 32'(bus.frame_count), 32'd5);
        check("fa_frame_data",  32'(bus.frame_data),  32'h1B1);
        check("fa_dct_count",   32'(bus.dct_count),   32'd1);
        check("fa_dct_buffer",  32'(bus.dct_buffer),  32'd3);
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        step();

        // Reset mid-frame with a held frame and cnt=9.
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(2'(i % 4));
        step();
        for (int i = 0; i < 9; i++) send(2'd2);
        check("pre_rst_dct_count", 32'(bus.dct_count),   32'd9);
        check("pre_rst_fv",        32'(bus.frame_valid), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.frame_ready = 1'b1;
        check("mid_rst_fv",        32'(bus.frame_valid), 32'd0);
        check("mid_rst_fdata",     32'(bus.frame_data),  32'd0);
        check("mid_rst_dct_count", 32'(bus.dct_count),   32'd0);
        check("mid_rst_drop",      32'(bus.drop_count),  32'd0);
        step();

        // End-of-test drain with 7 atoms buffered.
        for (int i = 0; i < 7; i++) send(2'd1);
        bus.test_ending = 1'b1; step(); bus.test_ending = 1'b0;
        seen7 = 1'b0;
        for (int k = 0; k < 20 && !bus.test_has_ended; k++) begin
            if (bus.frame_valid && bus.frame_count == 4'd7 && bus.frame_data == 30'h1555) seen7 = 1'b1;
            step();
        end
        check("drain_frame_seen", 32'(seen7),              32'd1);
        check("drain_ended",      32'(bus.test_has_ended), 32'd1);
        for (int i = 0; i < 5; i++) send(2'd3);
        step();
        check("ended_sticky",    32'(bus.test_has_ended), 32'd1);
        check("ended_drop",      32'(bus.drop_count),     32'd0);
        check("ended_dct_count", 32'(bus.dct_count),      32'd0);
        check("ended_ready",     32'(bus.atom_ready),     32'd0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
